// File: rtl/rr_sched_pkg.sv
// Shared constants and state encoding for the round-robin scheduler.
package rr_sched_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned TMO_DEF  = 15;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] pick_c,
    output logic [IW-1:0]   idx_c,
    output logic            any_c
);

    int unsigned  j;
    logic [IW-1:0] j_idx;

    always_comb begin
        pick_c = '0;
        idx_c  = '0;
        any_c  = 1'b0;
        j      = 0;
        j_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j     = (32'(ptr) + k) % NREQ;
            j_idx = IW'(j);
            if (!any_c && req[j_idx]) begin
                any_c         = 1'b1;
                idx_c         = j_idx;
                pick_c[j_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_scheduler.sv
// Round-robin arbiter sharing one request/response unit among NREQ requesters,
// with a bounded wait for the unit's result.
module rr_scheduler
    import rr_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned TMO  = TMO_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*DW-1:0] REQ_DATA,
    output logic [NREQ-1:0]    GNT,
    output logic               U_VALID,
    output logic [DW-1:0]      U_DATA,
    input  logic               U_READY,
    input  logic               U_DONE,
    input  logic [DW-1:0]      U_RESULT,
    output logic [NREQ-1:0]    RSP_VALID,
    output logic [DW-1:0]      RSP_DATA,
    output logic               RSP_ERR,
    output logic               BUSY
);

    localparam int unsigned IW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              u_valid_q, u_valid_d;
    logic [DW-1:0]     u_data_q, u_data_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (REQ),
        .ptr    (ptr_q),
        .pick_c (pick_oh),
        .idx_c  (pick_idx),
        .any_c  (pick_any)
    );

    // Next state; registered outputs are derived from the next state so they align with it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        u_data_d   = u_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d  = ST_ISSUE;
                    idx_d    = pick_idx;
                    gnt_d    = pick_oh;
                    u_data_d = REQ_DATA[pick_idx*DW +: DW];
                end
            end
            ST_ISSUE: begin
                if (u_valid_q && U_READY) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the timeout cycle still counts as success.
                if (U_DONE) begin
                    rsp_data_d = U_RESULT;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_d == CNT_W'(TMO)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            gnt_d = '0;
        end
        u_valid_d   = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP) ? gnt_d : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            u_valid_q   <= 1'b0;
            u_data_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            u_valid_q   <= u_valid_d;
            u_data_q    <= u_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign GNT       = gnt_q;
    assign U_VALID   = u_valid_q;
    assign U_DATA    = u_data_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RSP_ERR   = rsp_err_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_rr_scheduler.sv
// Bench for rr_scheduler: directed scenarios plus randomized transactions checked
// against a transaction-level round-robin model.
module tb_rr_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 15;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [3:0]      REQ = '0;
    logic [31:0]     REQ_DATA = '0;
    logic [3:0]      GNT;
    logic            U_VALID;
    logic [7:0]      U_DATA;
    logic            U_READY = 1'b0;
    logic            U_DONE = 1'b0;
    logic [7:0]      U_RESULT = '0;
    logic [3:0]      RSP_VALID;
    logic [7:0]      RSP_DATA;
    logic            RSP_ERR;
    logic            BUSY;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    rr_scheduler #(.NREQ(NREQ), .DW(DW), .TMO(TMO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_DATA  (REQ_DATA),
        .GNT       (GNT),
        .U_VALID   (U_VALID),
        .U_DATA    (U_DATA),
        .U_READY   (U_READY),
        .U_DONE    (U_DONE),
        .U_RESULT  (U_RESULT),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(GNT), 32'd0);
        chk({tag, "_uval"},  32'(U_VALID), 32'd0);
        chk({tag, "_udata"}, 32'(U_DATA), 32'd0);
        chk({tag, "_rspv"},  32'(RSP_VALID), 32'd0);
        chk({tag, "_rspd"},  32'(RSP_DATA), 32'd0);
        chk({tag, "_rspe"},  32'(RSP_ERR), 32'd0);
        chk({tag, "_busy"},  32'(BUSY), 32'd0);
    endtask

    // One full operation, starting and ending in an IDLE cycle (at posedge+1).
    // ddly: WAIT cycle (1-based) carrying U_DONE; 0 or >TMO means the unit never answers.
    task automatic run_txn(input logic [3:0] req, input logic [31:0] data, input int rdly,
                           input int ddly, input logic [7:0] result, input bit drop);
        int         e;
        int         nwait;
        bit         err;
        logic [7:0] op;
        logic [3:0] oh;
        e     = pick(req, m_ptr);
        oh    = 4'b0001 << e;
        op    = data[e*8 +: 8];
        err   = !(ddly >= 1 && ddly <= TMO);
        nwait = err ? TMO : ddly;

        REQ      = req;
        REQ_DATA = data;
        U_READY  = 1'b0;
        U_DONE   = 1'($urandom_range(0, 1));
        U_RESULT = 8'($urandom);
        step();
        if (drop) REQ = '0;
        for (int c = 0; c <= rdly; c++) begin
            chk("issue_gnt",   32'(GNT), 32'(oh));
            chk("issue_valid", 32'(U_VALID), 32'd1);
            chk("issue_data",  32'(U_DATA), 32'(op));
            chk("issue_busy",  32'(BUSY), 32'd1);
            chk("issue_rspv",  32'(RSP_VALID), 32'd0);
            U_READY  = (c == rdly);
            U_DONE   = 1'($urandom_range(0, 1));
            U_RESULT = 8'($urandom);
            step();
        end
        U_READY = 1'b0;
        for (int w = 1; w <= nwait; w++) begin
            chk("wait_gnt",   32'(GNT), 32'(oh));
            chk("wait_valid", 32'(U_VALID), 32'd0);
            chk("wait_rspv",  32'(RSP_VALID), 32'd0);
            U_DONE   = (w == ddly);
            U_RESULT = (w == ddly) ? result : 8'($urandom);
            step();
        end
        U_DONE   = 1'($urandom_range(0, 1));
        U_RESULT = 8'($urandom);
        chk("resp_valid", 32'(RSP_VALID), 32'(oh));
        chk("resp_data",  32'(RSP_DATA), err ? 32'd0 : 32'(result));
        chk("resp_err",   32'(RSP_ERR), 32'(err));
        chk("resp_gnt",   32'(GNT), 32'(oh));
        m_ptr = (e + 1) % NREQ;
        REQ   = '0;
        step();
        U_DONE = 1'b0;
        chk("idle_gnt",  32'(GNT), 32'd0);
        chk("idle_busy", 32'(BUSY), 32'd0);
        chk("idle_rspv", 32'(RSP_VALID), 32'd0);
        chk("idle_uval", 32'(U_VALID), 32'd0);
    endtask

    initial begin
        int dd;
        #2;
        RST = 1'b0;
        #1;
        chk_all_zero("reset");
        step();
        step();
        RST = 1'b1;
        m_ptr = 0;

        // All four requesting: strict rotation 0,1,2,3,0.
        for (int n = 0; n < 5; n++) begin
            run_txn(4'hF, $urandom, 0, 1, 8'($urandom), 1'b0);
        end

        // Minimum-latency single request.
        run_txn(4'b0001, 32'h0000_005A, 0, 1, 8'hA5, 1'b0);

        // Serve 2, then 0101 wraps to 0, then 2.
        run_txn(4'b0100, $urandom, 0, 2, 8'($urandom), 1'b0);
        run_txn(4'b0101, $urandom, 0, 1, 8'($urandom), 1'b0);
        run_txn(4'b0101, $urandom, 0, 3, 8'($urandom), 1'b0);

        // Timeout, then a normal operation; then done exactly on the timeout cycle.
        run_txn(4'b0010, $urandom, 0, 0, 8'($urandom), 1'b0);
        run_txn(4'b0010, $urandom, 0, 1, 8'h3C, 1'b0);
        run_txn(4'b1000, $urandom, 0, TMO, 8'hC3, 1'b0);

        // Unit not ready for 10 cycles; requester drops REQ mid-operation.
        run_txn(4'b0100, $urandom, 10, 2, 8'($urandom), 1'b0);
        run_txn(4'b1001, $urandom, 1, 4, 8'($urandom), 1'b1);

        // Reset while waiting on the unit.
        REQ      = 4'b0001;
        REQ_DATA = $urandom;
        U_READY  = 1'b1;
        step();
        step();
        U_READY = 1'b0;
        REQ     = '0;
        chk("pre_rst_busy", 32'(BUSY), 32'd1);
        RST = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        for (int c = 0; c < 3; c++) begin
            U_DONE = 1'b1;
            step();
            chk("in_rst_rspv", 32'(RSP_VALID), 32'd0);
        end
        U_DONE = 1'b0;
        RST    = 1'b1;
        m_ptr  = 0;
        run_txn(4'b1000, $urandom, 0, 1, 8'($urandom), 1'b0);
        run_txn(4'b1001, $urandom, 0, 1, 8'($urandom), 1'b0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       dd = 0;
                1:       dd = TMO;
                default: dd = int'($urandom_range(1, 5));
            endcase
            run_txn(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 3)), dd,
                    8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_scheduler.md
RR_SCHEDULER -- requirements
Module: rr_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the unit (2..8).
REQ-002 Parameter DW, default 8: operand/result width.
REQ-003 Parameter TMO, default 15: max WAIT cycles before timeout (1..255).
REQ-004 Clock: one clock, CLK, input, 1 bit; all state updates on its rising edge.
REQ-005 Reset: RST, input, 1 bit; asynchronous, active-low.
REQ-006 REQ  input  NREQ  per-requester request level; held until its RSP_VALID.
REQ-007 REQ_DATA  input  NREQ*DW  operands; requester i in bits [i*DW +: DW].
REQ-008 GNT  output  NREQ  one-hot grant, requester currently owning the unit.
REQ-009 U_VALID  output  1  operand valid toward the shared unit.
REQ-010 U_DATA  output  DW  latched operand of the granted requester.
REQ-011 U_READY  input  1  shared unit accepts operand when U_VALID&U_READY.
REQ-012 U_DONE  input  1  one-cycle result strobe from the shared unit.
REQ-013 U_RESULT  input  DW  result, valid with U_DONE.
REQ-014 RSP_VALID  output  NREQ  one-cycle, one-hot response strobe.
REQ-015 RSP_DATA  output  DW  result, valid with RSP_VALID.
REQ-016 RSP_ERR  output  1  response is a timeout, valid with RSP_VALID.
REQ-017 BUSY  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if any REQ bit set, select the first set bit at or after pointer PTR (wrapping NREQ-1 -> 0), latch index and its REQ_DATA, go to ISSUE next cycle.
REQ-020 ISSUE: U_VALID=1, U_DATA=latched operand; on U_VALID&U_READY go to WAIT and clear the wait counter.
REQ-021 ISSUE holds indefinitely while U_READY=0; no timeout in ISSUE.
REQ-022 WAIT: counter increments each cycle; U_DONE -> latch U_RESULT, RSP_ERR=0, go to RESP.
REQ-023 WAIT: counter reaching TMO without U_DONE -> RSP_DATA=0, RSP_ERR=1, go to RESP.
REQ-024 U_DONE in the same cycle as counter==TMO: U_DONE wins (RSP_ERR=0).
REQ-025 U_DONE outside WAIT is ignored.
REQ-026 RESP: RSP_VALID[idx]=1 for exactly one cycle; PTR<=(idx+1) mod NREQ; return to IDLE.
REQ-027 GNT[idx]=1 from ISSUE through RESP inclusive; GNT=0 in IDLE.
REQ-028 Minimum request-to-response latency: 4 cycles (IDLE sample, ISSUE with U_READY=1, WAIT with U_DONE, RESP).
REQ-029 REQ changes after latching do not affect the operation in flight; deasserted REQ mid-operation still receives its response.
REQ-030 No requester is granted twice while another requester continuously requests (round-robin fairness).

Reset
REQ-031 RST low: state=IDLE, PTR=0, counter=0, GNT=0, U_VALID=0, U_DATA=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, BUSY=0, immediately and asynchronously.
REQ-032 Reset mid-operation abandons the operation with no response; the first post-reset grant starts search from requester 0.

Structure
REQ-033 State encoding constants and default parameter values reside in shared package rr_sched_pkg.
REQ-034 Round-robin selection is sub-module rr_pick (combinational: REQ, PTR -> one-hot pick, index, any).

Verification
REQ-035 REQ=4'b0001, data 8'h5A, U_READY=1, U_DONE 1 cycle after accept with 8'hA5 -> RSP_VALID=4'b0001, RSP_DATA=8'hA5, RSP_ERR=0, 4 cycles after REQ.
REQ-036 REQ=4'b1111 held, unit always completes -> grant order 0,1,2,3,0; each RSP_VALID matches grant.
REQ-037 PTR=3 after serving 2, REQ=4'b0101 -> requester 0 granted (wrap), then 2.
REQ-038 U_DONE never asserted, TMO=15 -> RSP_VALID after 15 WAIT cycles, RSP_ERR=1, RSP_DATA=8'h00; next request served normally.
REQ-039 U_READY low 10 cycles -> U_VALID/U_DATA stable 10 cycles, no timeout, accepts on cycle 11.
REQ-040 RST low during WAIT -> all outputs 0 same cycle, no RSP_VALID; after release REQ=4'b1000 granted GNT=4'b1000.
